uart_rx_fifo: RTL and testbench

Receive buffer sitting directly downstream of the UART receiver. It captures each received character and its frame/parity status on the receiver's one-cycle `rx_success` pulse. It presents the oldest entry to the register/bus interface in first-word-fall-through form. It returns `fifo_full` to the receiver, maintains the sticky overrun flag, and raises level-threshold and (optionally) character-timeout interrupts.

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_rx_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: error-bit positions, line-format encodings,
// receive FIFO trigger-level encoding and small decode helpers.
package uart_pkg;

   // Bit positions inside the receiver error[2:0] status word.
   localparam int ERR_FRAME   = 2;
   localparam int ERR_PARITY  = 1;
   localparam int ERR_OVERRUN = 0;

   // Parity mode encoding of the line-control register.
   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_ODD   = 3'd1,
      PAR_EVEN  = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } parity_e;

   // Character length encoding of the line-control register.
   typedef enum logic [1:0] {
      DBITS_5 = 2'd0,
      DBITS_6 = 2'd1,
      DBITS_7 = 2'd2,
      DBITS_8 = 2'd3
   } data_bits_e;

   // Receive FIFO threshold select.
   typedef enum logic [1:0] {
      TRIG_ONE       = 2'd0,
      TRIG_QUARTER   = 2'd1,
      TRIG_HALF      = 2'd2,
      TRIG_NEAR_FULL = 2'd3
   } trig_level_e;

   // Extract the {frame, parity} pair stored alongside each character.
   function automatic logic [1:0] rx_err_from_status(input logic [2:0] error);
      return {error[ERR_FRAME], error[ERR_PARITY]};
   endfunction

   // Occupancy threshold (in entries) for a trigger level at a given depth.
   function automatic int trig_threshold(input trig_level_e lvl, input int depth);
      int thr;
      case (lvl)
         TRIG_ONE:       thr = 1;
         TRIG_QUARTER:   thr = depth / 4;
         TRIG_HALF:      thr = depth / 2;
         TRIG_NEAR_FULL: thr = depth - 2;
         default:        thr = 1;
      endcase
      return thr;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage: DEPTH x W register array, one synchronous write
// port and one asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = 10
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);

   logic [W-1:0] mem_q [DEPTH];

   // Write the new entry at the write pointer.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular FIFO of {frame, parity, data} entries in
// first-word-fall-through form, with overrun, threshold and optional
// character-timeout flags.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle-timeout
// counter; otherwise timeout_irq is tied low and timeout_cycles is ignored.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DW    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fifo_en,
   input  logic                   fifo_clr,
   input  logic                   rx_success,
   input  logic [DW-1:0]          rx_data,
   input  logic [1:0]             rx_err,
   input  logic                   rd_en,
   output logic [DW-1:0]          rd_data,
   output logic [1:0]             rd_err,
   output logic                   empty,
   output logic                   fifo_full,
   output logic [$clog2(DEPTH):0] count,
   input  logic [1:0]             trig_level,
   output logic                   thr_irq,
   output logic                   ovr_err,
   input  logic                   ovr_clr,
   input  logic [19:0]            timeout_cycles,
   output logic                   timeout_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DW + 2;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          thr_q, thr_d;
   logic          ovr_q, ovr_d;
   logic          fifo_en_q;

   logic          flush_s;
   logic          pop_s;
   logic          wr_s;
   logic          ovr_set_s;
   logic [CW-1:0] cap_s;
   logic [CW-1:0] thr_lvl_s;
   logic [EW-1:0] rdata_s;

   // Qualify the raw strobes: flush beats everything, pops need data,
   // writes need room (a same-cycle pop frees a slot when full).
   always_comb begin
      flush_s   = fifo_clr | (fifo_en ^ fifo_en_q);
      pop_s     = rd_en & ~empty_q & ~flush_s;
      wr_s      = rx_success & ~flush_s & (~full_q | pop_s);
      ovr_set_s = rx_success & ~flush_s & full_q & ~pop_s;
   end

   // Effective capacity and interrupt threshold for the current mode.
   always_comb begin
      if (fifo_en) begin
         cap_s     = CW'(DEPTH);
         thr_lvl_s = CW'(trig_threshold(trig_level_e'(trig_level), DEPTH));
      end else begin
         cap_s     = CW'(1);
         thr_lvl_s = CW'(1);
      end
   end

   // Next pointers, occupancy and the flags derived from the new occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_s) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (wr_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      empty_d = (count_d == {CW{1'b0}});
      full_d  = (count_d == cap_s);
      thr_d   = (count_d >= thr_lvl_s);
      if (ovr_set_s) begin
         ovr_d = 1'b1;
      end else if (ovr_clr) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Pointer, occupancy and status flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         count_q   <= {CW{1'b0}};
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         thr_q     <= 1'b0;
         ovr_q     <= 1'b0;
         fifo_en_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         thr_q     <= thr_d;
         ovr_q     <= ovr_d;
         fifo_en_q <= fifo_en;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_s),
      .waddr_i (wr_ptr_q),
      .wdata_i ({rx_err, rx_data}),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata_s)
   );

   // Head entry is shown only while the buffer holds data.
   always_comb begin
      if (empty_q) begin
         rd_data = {DW{1'b0}};
         rd_err  = 2'b00;
      end else begin
         rd_data = rdata_s[DW-1:0];
         rd_err  = rdata_s[EW-1:DW];
      end
   end

   assign empty     = empty_q;
   assign fifo_full = full_q;
   assign count     = count_q;
   assign thr_irq   = thr_q;
   assign ovr_err   = ovr_q;

`ifdef UART_RX_FIFO_TIMEOUT_EN
   logic [19:0] idle_q, idle_d;
   logic        tmo_q, tmo_d;

   // Idle counter runs while data waits; any FIFO activity restarts it.
   always_comb begin
      idle_d = idle_q;
      tmo_d  = tmo_q;
      if (flush_s | wr_s | pop_s) begin
         idle_d = 20'd0;
         tmo_d  = 1'b0;
      end else if (count_q != {CW{1'b0}}) begin
         if (idle_q != 20'hFFFFF) begin
            idle_d = idle_q + 20'd1;
         end else begin
            idle_d = idle_q;
         end
         if ((timeout_cycles != 20'd0) && (idle_q >= timeout_cycles)) begin
            tmo_d = 1'b1;
         end else begin
            tmo_d = tmo_q;
         end
      end else begin
         idle_d = 20'd0;
         tmo_d  = tmo_q;
      end
   end

   // Idle counter and timeout flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q <= 20'd0;
         tmo_q  <= 1'b0;
      end else begin
         idle_q <= idle_d;
         tmo_q  <= tmo_d;
      end
   end

   assign timeout_irq = tmo_q;
`else
   logic unused_timeout_s;
   assign unused_timeout_s = ^timeout_cycles;
   assign timeout_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue scoreboard models the FIFO
// contents, capacity, threshold and overrun flag.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_en;
   logic          fifo_clr;
   logic          rx_success;
   logic [DW-1:0] rx_data;
   logic [1:0]    rx_err;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic [1:0]    rd_err;
   logic          empty;
   logic          fifo_full;
   logic [4:0]    count;
   logic [1:0]    trig_level;
   logic          thr_irq;
   logic          ovr_err;
   logic          ovr_clr;
   logic [19:0]   timeout_cycles;
   logic          timeout_irq;

   logic [9:0] sb[$];
   bit         m_ovr;
   int         n_vec;
   int         n_err;

   always #10 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .fifo_en        (fifo_en),
      .fifo_clr       (fifo_clr),
      .rx_success     (rx_success),
      .rx_data        (rx_data),
      .rx_err         (rx_err),
      .rd_en          (rd_en),
      .rd_data        (rd_data),
      .rd_err         (rd_err),
      .empty          (empty),
      .fifo_full      (fifo_full),
      .count          (count),
      .trig_level     (trig_level),
      .thr_irq        (thr_irq),
      .ovr_err        (ovr_err),
      .ovr_clr        (ovr_clr),
      .timeout_cycles (timeout_cycles),
      .timeout_irq    (timeout_irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_cap();
      return fifo_en ? DEPTH : 1;
   endfunction

   function automatic int m_thr();
      int t;
      if (!fifo_en) return 1;
      case (trig_level)
         2'd0:    t = 1;
         2'd1:    t = DEPTH / 4;
         2'd2:    t = DEPTH / 2;
         default: t = DEPTH - 2;
      endcase
      return t;
   endfunction

   task automatic status(input string tag);
      logic [9:0] head;
      head = (sb.size() == 0) ? 10'd0 : sb[0];
      chk({tag, ".count"}, 32'(count), 32'(sb.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
      chk({tag, ".full"},  32'(fifo_full), 32'(sb.size() == m_cap()));
      chk({tag, ".thr"},   32'(thr_irq), 32'(sb.size() >= m_thr()));
      chk({tag, ".ovr"},   32'(ovr_err), 32'(m_ovr));
      chk({tag, ".data"},  32'(rd_data), 32'(head[7:0]));
      chk({tag, ".err"},   32'(rd_err), 32'(head[9:8]));
   endtask

   task automatic wr(input logic [7:0] d, input logic [1:0] e);
      rx_success = 1'b1;
      rx_data    = d;
      rx_err     = e;
      tick();
      rx_success = 1'b0;
      if (sb.size() < m_cap()) sb.push_back({e, d});
      else m_ovr = 1'b1;
   endtask

   task automatic pop();
      logic [9:0] head;
      head = (sb.size() == 0) ? 10'd0 : sb[0];
      chk("pop.data", 32'(rd_data), 32'(head[7:0]));
      chk("pop.err",  32'(rd_err),  32'(head[9:8]));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
   endtask

   task automatic wr_pop(input logic [7:0] d);
      rx_success = 1'b1;
      rx_data    = d;
      rx_err     = 2'b00;
      rd_en      = 1'b1;
      tick();
      rx_success = 1'b0;
      rd_en      = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
      sb.push_back({2'b00, d});
   endtask

   task automatic set_en(input logic v);
      fifo_en = v;
      tick();
      sb.delete();
   endtask

   initial begin
      logic tmo_exp;
      n_vec = 0; n_err = 0; m_ovr = 1'b0;
      rst = 1'b1; fifo_en = 1'b1; fifo_clr = 1'b0; rx_success = 1'b0;
      rx_data = 8'h00; rx_err = 2'b00; rd_en = 1'b0; trig_level = 2'd0;
      ovr_clr = 1'b0; timeout_cycles = 20'd100;
      tick(); tick();
      status("reset");
      chk("reset.tmo", 32'(timeout_irq), 32'd0);
      rst = 1'b0;
      tick(); tick();

      // Basic three-character write and readback.
      wr(8'h41, 2'b00); wr(8'h42, 2'b10); wr(8'h43, 2'b01);
      status("w3");
      for (int i = 0; i < 3; i++) pop();
      status("drain3");
      pop();
      status("pop_empty");

      // Fill, overrun, clear, then full write+pop.
      for (int i = 0; i < DEPTH; i++) wr(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      status("fill");
      wr(8'h55, 2'b11);
      status("ovr");
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; m_ovr = 1'b0;
      status("ovr_clr");
      wr_pop(8'h77);
      status("full_wrpop");
      while (sb.size() != 0) pop();
      status("drain_full");

      // Write+pop on an empty FIFO: only the write lands.
      wr_pop(8'h21);
      status("empty_wrpop");

      // Flush coinciding with a write drops the character, keeps ovr.
      wr(8'h22, 2'b00); wr(8'h23, 2'b00);
      m_ovr = 1'b1;
      for (int i = 0; i < DEPTH - 3; i++) wr(8'(i), 2'b00);
      wr(8'h99, 2'b00);
      wr(8'h9A, 2'b00);
      status("ovr2");
      fifo_clr = 1'b1; rx_success = 1'b1; rx_data = 8'h66;
      tick();
      fifo_clr = 1'b0; rx_success = 1'b0;
      sb.delete();
      status("clr_wr");
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; m_ovr = 1'b0;

      // Holding-register mode.
      set_en(1'b0);
      status("en0");
      wr(8'h10, 2'b00);
      status("hold1");
      wr(8'h11, 2'b01);
      status("hold_ovr");
      set_en(1'b1);
      status("en1");
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0; m_ovr = 1'b0;

      // Threshold at half, then near-full.
      trig_level = 2'd2; tick();
      for (int i = 0; i < 8; i++) begin
         wr(8'h30 + 8'(i), 2'b00);
         status("thr_half");
      end
      pop();
      status("thr_fall");
      trig_level = 2'd3; tick();
      while (sb.size() < DEPTH - 2) begin
         wr(8'h40, 2'b00);
         status("thr_nf");
      end
      pop();
      status("thr_nf_fall");
      while (sb.size() != 0) pop();
      trig_level = 2'd0; tick();

      // Character timeout.
`ifdef UART_RX_FIFO_TIMEOUT_EN
      tmo_exp = 1'b1;
`else
      tmo_exp = 1'b0;
`endif
      wr(8'h5A, 2'b00);
      for (int i = 0; i < 100; i++) tick();
      chk("tmo.before", 32'(timeout_irq), 32'd0);
      tick();
      chk("tmo.rise", 32'(timeout_irq), 32'(tmo_exp));
      pop();
      chk("tmo.clear", 32'(timeout_irq), 32'd0);
      status("tmo_done");

      // Asynchronous reset mid-operation.
      wr(8'h01, 2'b00); wr(8'h02, 2'b00);
      #3 rst = 1'b1;
      #1;
      sb.delete(); m_ovr = 1'b0;
      status("async_rst");
      tick();
      rst = 1'b0;
      tick(); tick();
      status("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
